branch_predictor: RTL and testbench

Parametrised dynamic branch predictor for the fetch stage: a direct-mapped table of 2-bit saturating counters plus tag and target (BHT+BTB) replaces the fixed "always take conditional branches" policy. It is looked up with the fetch address in the same cycle the instruction memory is addressed and returns its prediction one cycle later, aligned with the fetched instruction word. It is trained from the decode-stage branch resolution. A built-in clear sequencer invalidates the table after reset.

---
 rtl/bp_pkg.sv | 20 ++
 rtl/bp_table.sv | 34 +++
 rtl/branch_predictor.sv | 177 +++++++++++++++++
 tb/tb_branch_predictor.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit direction counter, sequencer
// state and the saturating counter step.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'd0;
  localparam ctr_t CTR_WNT = 2'd1;
  localparam ctr_t CTR_WT  = 2'd2;
  localparam ctr_t CTR_ST  = 2'd3;

  typedef enum logic {CLEAR, RUN} bp_state_t;

  // Saturates at both ends: never wraps 3->0 or 0->3.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    if (taken) return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
    else       return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/bp_table.sv
// Simple dual-port predictor table: one synchronous read port, one write port
// with separate enables for the metadata and target fields.
module bp_table #(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6,
  parameter int META_W  = 11,
  parameter int TGT_W   = 32
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [META_W-1:0] rd_meta,
  output logic [TGT_W-1:0]  rd_tgt,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_meta_en,
  input  logic [META_W-1:0] wr_meta,
  input  logic              wr_tgt_en,
  input  logic [TGT_W-1:0]  wr_tgt
);

  logic [META_W-1:0] meta_mem [ENTRIES];
  logic [TGT_W-1:0]  tgt_mem  [ENTRIES];

  // Read-before-write on a same-address collision; the top level bypasses it.
  always_ff @(posedge clk) begin
    if (wr_meta_en) meta_mem[wr_idx] <= wr_meta;
    if (wr_tgt_en)  tgt_mem[wr_idx]  <= wr_tgt;
    if (rd_en) begin
      rd_meta <= meta_mem[rd_idx];
      rd_tgt  <= tgt_mem[rd_idx];
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT+BTB for fetch: lookup read at edge E, registered prediction
// after E+1; trained from decode resolution; table cleared by a sequencer after reset.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lookup_en,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            update_en,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target,
  output logic            ready
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    ctr_t             ctr;
  } meta_t;

  localparam int META_W = $bits(meta_t);

  bp_state_t        state;
  logic [IDX_W-1:0] clr_idx;
  logic             run;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             unused_pc;

  assign run    = (state == RUN);
  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx = update_pc[IDX_W+1:2];
  assign up_tag = update_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc = ^{lookup_pc[XLEN-1:IDX_W+TAG_W+2], lookup_pc[1:0],
                       update_pc[XLEN-1:IDX_W+TAG_W+2], update_pc[1:0]};

  // Flop copy of the metadata so an update can read-modify-write in one cycle
  // while the RAM read port stays dedicated to fetch lookups.
  meta_t sh_meta [ENTRIES];
  meta_t up_old, up_meta;
  logic  up_hit, up_meta_we, up_tgt_we;

  assign up_old     = sh_meta[up_idx];
  assign up_hit     = up_old.valid && (up_old.tag == up_tag);
  assign up_meta_we = run && update_en && (up_hit || update_taken);
  assign up_tgt_we  = run && update_en && update_taken;

  always_comb begin
    up_meta       = '0;
    up_meta.valid = 1'b1;
    up_meta.tag   = up_tag;
    up_meta.ctr   = up_hit ? ctr_next(up_old.ctr, update_taken) : CTR_WT;
  end

  // Write port: clear sequencer owns it in CLEAR, resolved branches in RUN.
  logic [IDX_W-1:0] wr_idx;
  meta_t            wr_meta;
  logic             wr_meta_en, wr_tgt_en;

  always_comb begin
    wr_idx     = clr_idx;
    wr_meta    = '0;
    wr_meta_en = 1'b1;
    wr_tgt_en  = 1'b0;
    if (run) begin
      wr_idx     = up_idx;
      wr_meta    = up_meta;
      wr_meta_en = up_meta_we;
      wr_tgt_en  = up_tgt_we;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_meta_en) sh_meta[wr_idx] <= wr_meta;
  end

  logic             lk_en;
  logic [META_W-1:0] rd_meta_raw;
  meta_t            rd_meta;
  logic [XLEN-1:0]  rd_tgt;

  assign lk_en   = run && lookup_en;
  assign rd_meta = meta_t'(rd_meta_raw);

  bp_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .META_W  (META_W),
    .TGT_W   (XLEN)
  ) u_table (
    .clk        (clk),
    .rd_en      (lk_en),
    .rd_idx     (lk_idx),
    .rd_meta    (rd_meta_raw),
    .rd_tgt     (rd_tgt),
    .wr_idx     (wr_idx),
    .wr_meta_en (wr_meta_en),
    .wr_meta    (wr_meta),
    .wr_tgt_en  (wr_tgt_en),
    .wr_tgt     (update_target)
  );

  // Clear sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + IDX_W'(1);
      if (clr_idx == IDX_W'(ENTRIES - 1)) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end
  end

  // Lookup stage: tag and same-edge update capture for the bypass.
  logic             lookup_q;
  logic [TAG_W-1:0] tag_q;
  logic             byp_vld, byp_tgt_vld;
  meta_t            byp_meta;
  logic [XLEN-1:0]  byp_tgt;

  always_ff @(posedge clk) begin
    if (rst) begin
      lookup_q    <= 1'b0;
      tag_q       <= '0;
      byp_vld     <= 1'b0;
      byp_tgt_vld <= 1'b0;
      byp_meta    <= '0;
      byp_tgt     <= '0;
    end else begin
      lookup_q    <= lk_en;
      if (lk_en) tag_q <= lk_tag;
      byp_vld     <= lk_en && up_meta_we && (up_idx == lk_idx);
      byp_tgt_vld <= up_tgt_we;
      byp_meta    <= up_meta;
      byp_tgt     <= update_target;
    end
  end

  meta_t           cur_meta;
  logic [XLEN-1:0] cur_tgt;
  logic            cur_hit;

  // A not-taken hit leaves the target untouched, so the RAM copy is still current.
  assign cur_meta = byp_vld ? byp_meta : rd_meta;
  assign cur_tgt  = (byp_vld && byp_tgt_vld) ? byp_tgt : rd_tgt;
  assign cur_hit  = cur_meta.valid && (cur_meta.tag == tag_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else if (lookup_q) begin
      pred_hit    <= cur_hit;
      pred_taken  <= cur_hit && cur_meta.ctr[1];
      pred_target <= cur_hit ? cur_tgt : '0;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expectations queued at lookup drive,
// checked when the registered prediction appears.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lookup_en = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        pred_hit, pred_taken, ready;
  logic [31:0] pred_target;
  logic        update_en = 1'b0;
  logic [31:0] update_pc = '0;
  logic        update_taken = 1'b0;
  logic [31:0] update_target = '0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(64), .TAG_W(8), .XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .lookup_en     (lookup_en),
    .lookup_pc     (lookup_pc),
    .pred_hit      (pred_hit),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .update_en     (update_en),
    .update_pc     (update_pc),
    .update_taken  (update_taken),
    .update_target (update_target),
    .ready         (ready)
  );

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  bit         tb_run = 1'b0;
  logic [1:0] lk_pipe = 2'b00;

  // Prediction for a lookup sampled at edge E is registered at E+1.
  always @(posedge clk) begin : monitor
    exp_t e;
    lk_pipe = {lk_pipe[0], lookup_en & tb_run & ~rst};
    #1;
    if (lk_pipe[1]) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow: prediction hit=%0b with nothing expected", pred_hit);
      end else begin
        e = exp_q.pop_front();
        if ({pred_hit, pred_taken, pred_target} !== {e.hit, e.taken, e.tgt}) begin
          bad++;
          $display("FAIL lookup: got hit=%0b taken=%0b tgt=%h, want hit=%0b taken=%0b tgt=%h",
                   pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
        end
      end
    end
  end

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    @(negedge clk);
    update_en = 1'b1; update_pc = pc; update_taken = tk; update_target = tg;
    @(negedge clk);
    update_en = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc, input logic h, input logic tk, input logic [31:0] tg);
    @(negedge clk);
    lookup_en = 1'b1; lookup_pc = pc;
    exp_q.push_back('{h, tk, tg});
    @(negedge clk);
    lookup_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge clk); #2; n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d predictions outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_clear(input string name, input bit probe);
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
      if (probe && n == 10) begin lookup_en = 1'b1; lookup_pc = 32'h100; end
      if (probe && n == 11) lookup_en = 1'b0;
      if (probe && n == 12) begin
        total++;
        if (pred_hit !== 1'b0) begin
          bad++;
          $display("FAIL clear_lookup: pred_hit=%0b want 0", pred_hit);
        end
      end
      if (probe && n == 20) begin
        update_en = 1'b1; update_pc = 32'h504; update_taken = 1'b1; update_target = 32'h55;
      end
      if (probe && n == 21) update_en = 1'b0;
    end
    total++;
    if (n != 64) begin
      bad++;
      $display("FAIL %s: ready after %0d cycles, want 64", name, n);
    end
    tb_run = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({pred_hit, pred_taken, pred_target} !== 34'd0) begin
      bad++;
      $display("FAIL reset_outputs: hit=%0b taken=%0b tgt=%h want all 0", pred_hit, pred_taken, pred_target);
    end
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: ready=%0b want 0", ready);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_clear("clear_latency", 1'b1);
    // The update issued during clear must have been dropped.
    look(32'h504, 1'b0, 1'b0, 32'h0);
    drain();
  endtask

  task automatic test_alloc();
    upd(32'h100, 1'b1, 32'h80);
    look(32'h100, 1'b1, 1'b1, 32'h80);
    look(32'h200, 1'b0, 1'b0, 32'h0);
    drain();
  endtask

  task automatic test_saturation();
    repeat (3) upd(32'h100, 1'b1, 32'h80);
    upd(32'h100, 1'b0, 32'hDEAD);
    look(32'h100, 1'b1, 1'b1, 32'h80);
    repeat (2) upd(32'h100, 1'b0, 32'hDEAD);
    look(32'h100, 1'b1, 1'b0, 32'h80);
    upd(32'h100, 1'b0, 32'hDEAD);
    look(32'h100, 1'b1, 1'b0, 32'h80);
    upd(32'h100, 1'b1, 32'h1234);
    look(32'h100, 1'b1, 1'b0, 32'h1234);
    upd(32'h100, 1'b1, 32'h1234);
    look(32'h100, 1'b1, 1'b1, 32'h1234);
    drain();
  endtask

  task automatic test_nt_miss();
    upd(32'h40, 1'b0, 32'h999);
    look(32'h40, 1'b0, 1'b0, 32'h0);
    look(32'h100, 1'b1, 1'b1, 32'h1234);
    drain();
  endtask

  task automatic test_bypass();
    @(negedge clk);
    update_en = 1'b1; update_pc = 32'h300; update_taken = 1'b1; update_target = 32'h88;
    lookup_en = 1'b1; lookup_pc = 32'h300;
    exp_q.push_back('{1'b1, 1'b1, 32'h88});
    @(negedge clk);
    update_taken = 1'b0; update_target = 32'h77;
    exp_q.push_back('{1'b1, 1'b0, 32'h88});
    @(negedge clk);
    update_taken = 1'b1; update_target = 32'h88;
    lookup_pc = 32'h104;
    exp_q.push_back('{1'b0, 1'b0, 32'h0});
    @(negedge clk);
    update_en = 1'b0; lookup_en = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [4];
    exp_t        ex  [4];
    pcs[0] = 32'h300; ex[0] = '{1'b1, 1'b1, 32'h88};
    pcs[1] = 32'h100; ex[1] = '{1'b0, 1'b0, 32'h0};
    pcs[2] = 32'h40;  ex[2] = '{1'b0, 1'b0, 32'h0};
    pcs[3] = 32'h200; ex[3] = '{1'b0, 1'b0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      lookup_en = 1'b1; lookup_pc = pcs[i];
      exp_q.push_back(ex[i]);
    end
    @(negedge clk);
    lookup_en = 1'b0;
    drain();
  endtask

  task automatic test_stall_and_reset();
    look(32'h300, 1'b1, 1'b1, 32'h88);
    drain();
    @(negedge clk);
    lookup_pc = 32'h200;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h88}) begin
        bad++;
        $display("FAIL stall_hold[%0d]: hit=%0b taken=%0b tgt=%h want 1 1 00000088",
                 i, pred_hit, pred_taken, pred_target);
      end
    end
    @(negedge clk);
    rst = 1'b1; tb_run = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({pred_hit, pred_taken, pred_target, ready} !== 35'd0) begin
      bad++;
      $display("FAIL midrun_reset: hit=%0b taken=%0b tgt=%h ready=%0b want all 0",
               pred_hit, pred_taken, pred_target, ready);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_clear("reclear_latency", 1'b0);
    look(32'h100, 1'b0, 1'b0, 32'h0);
    look(32'h300, 1'b0, 1'b0, 32'h0);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alloc();
    test_saturation();
    test_nt_miss();
    test_bypass();
    test_back_to_back();
    test_stall_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
